sseg_scan_controller: RTL and testbench

- Time-multiplexing scheduler for the 8-digit seven-segment display.
- Sequences the shared digit driver across all digits at a prescaled refresh rate, presenting one digit value, digit index, DP and enable per slot.
- Latches a tear-free snapshot of the display value once per frame and performs leading-zero blanking.
- Sits between the stopwatch BCD datapath and the seven-segment digit driver (driver inputs num, active_digit, DP_ctrl, en).

---
 rtl/sseg_scan_controller.sv | 106 ++++++++++
 tb/tb_sseg_scan_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_scan_controller: digit-multiplex scheduler with per-frame snapshot and
// leading-zero blanking.  Rev 1.0
// ---------------------------------------------------------------------------
module sseg_scan_controller #(
  parameter int FINAL_VALUE = 500000,
  parameter int DIGITS      = 8,
  parameter int BITS        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  display_on,
  input  logic                  lz_blank,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [3:0]            num,
  output logic [BITS-1:0]       active_digit,
  output logic                  dp_ctrl,
  output logic                  en,
  output logic                  frame_done
);

  localparam int              CW         = $clog2(FINAL_VALUE);
  localparam int              SLOTS      = 1 << BITS;
  localparam int              VW         = 4 * SLOTS;
  localparam logic [CW-1:0]   C_CNT_LAST = CW'(FINAL_VALUE - 1);
  localparam logic [CW-1:0]   C_CNT_PRE  = CW'(FINAL_VALUE - 2);
  localparam logic [BITS-1:0] C_IDX_LAST = BITS'(DIGITS - 1);

  logic [CW-1:0]         r_cnt;
  logic [BITS-1:0]       r_idx;
  logic [4*DIGITS-1:0]   r_snap_val;
  logic [DIGITS-1:0]     r_snap_dp;
  logic                  r_snap_lz;
  logic                  r_started;

  logic                  w_tick;
  logic                  w_frame_tick;
  logic [BITS-1:0]       w_nidx;
  logic [4*DIGITS-1:0]   w_nval;
  logic [DIGITS-1:0]     w_ndp;
  logic                  w_nlz;
  logic                  w_nstarted;
  logic [VW-1:0]         w_val_ext;
  logic [SLOTS-1:0]      w_dp_ext;
  logic [SLOTS-1:0]      w_blank;
  logic                  w_run;

  // Outputs are registered from next-state values so they follow the tick by one cycle.
  always_comb begin
    w_tick       = (r_cnt == C_CNT_LAST);
    w_frame_tick = w_tick && (r_idx == C_IDX_LAST);
    w_nidx       = r_idx;
    if (w_tick) begin
      w_nidx = (r_idx == C_IDX_LAST) ? '0 : r_idx + BITS'(1);
    end
    w_nval     = w_frame_tick ? value    : r_snap_val;
    w_ndp      = w_frame_tick ? dp_mask  : r_snap_dp;
    w_nlz      = w_frame_tick ? lz_blank : r_snap_lz;
    w_nstarted = w_frame_tick | r_started;
    w_val_ext  = VW'(w_nval);
    w_dp_ext   = SLOTS'(w_ndp);

    // Walk down from the top digit; blanking holds while digits and DPs stay zero.
    w_blank = '0;
    w_run   = w_nlz;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      w_run = w_run && (w_val_ext[4*i +: 4] == 4'd0) && !w_dp_ext[i];
      if (i > 0) begin
        w_blank[i] = w_run;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= C_IDX_LAST;
      r_snap_val   <= '0;
      r_snap_dp    <= '0;
      r_snap_lz    <= 1'b0;
      r_started    <= 1'b0;
      num          <= 4'd0;
      active_digit <= C_IDX_LAST;
      dp_ctrl      <= 1'b0;
      en           <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + CW'(1);
      r_idx        <= w_nidx;
      r_snap_val   <= w_nval;
      r_snap_dp    <= w_ndp;
      r_snap_lz    <= w_nlz;
      r_started    <= w_nstarted;
      num          <= w_val_ext[{w_nidx, 2'b00} +: 4];
      active_digit <= w_nidx;
      dp_ctrl      <= w_dp_ext[w_nidx] && !w_blank[w_nidx];
      en           <= display_on && w_nstarted && !w_blank[w_nidx];
      // Predict next cycle's frame tick so the pulse lands in the tick cycle itself.
      frame_done   <= (r_cnt == C_CNT_PRE) && (r_idx == C_IDX_LAST);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_controller.sv
`default_nettype none
// Self-checking bench for sseg_scan_controller (FINAL_VALUE=4, DIGITS=8).
module tb_sseg_scan_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        display_on;
  logic        lz_blank;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [3:0]  num;
  logic [2:0]  active_digit;
  logic        dp_ctrl;
  logic        en;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  sseg_scan_controller #(.FINAL_VALUE(4), .DIGITS(8), .BITS(3)) dut (
    .clk(clk), .reset(reset), .display_on(display_on), .lz_blank(lz_blank),
    .value(value), .dp_mask(dp_mask), .num(num), .active_digit(active_digit),
    .dp_ctrl(dp_ctrl), .en(en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: cycle k after reset shows slot floor(k/4) (index starts at 7),
  // frames start at cycles 3, 35, 67, ...; the display uses the last captured frame.
  int          m_k;
  bit          m_valid = 0;
  logic [31:0] m_val;
  logic [7:0]  m_dp;
  logic        m_lz;
  logic        m_prev_disp;

  always @(negedge clk) begin
    if (reset) begin
      m_k = 0; m_val = 0; m_dp = 0; m_lz = 0; m_prev_disp = 0; m_valid = 1;
    end else if (m_valid) begin
      int idx, hi;
      bit lit, started;
      idx = (m_k / 4 + 7) % 8;
      started = (m_k >= 4);
      hi = 0;
      for (int i = 0; i < 8; i++)
        if (((m_val >> (4 * i)) & 32'hF) != 0 || m_dp[i]) hi = i;
      lit = !m_lz || (idx <= hi);
      chk("model_active", active_digit, idx);
      chk("model_num", num, (m_val >> (4 * idx)) & 32'hF);
      chk("model_dp", dp_ctrl, m_dp[idx] && lit);
      chk("model_en", en, m_prev_disp && started && lit);
      chk("model_frame_done", frame_done, (m_k % 32) == 3);
      if ((m_k % 32) == 3) begin
        m_val = value; m_dp = dp_mask; m_lz = lz_blank;
      end
      m_prev_disp = display_on;
      m_k++;
    end
  end

  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 40) begin @(negedge clk); n++; end
    chk("wait_frame", frame_done, 1);
  endtask

  task automatic wait_digit(input int d);
    int n = 0;
    @(negedge clk);
    while (active_digit != d && n < 40) begin @(negedge clk); n++; end
    chk("wait_digit", active_digit, d);
  endtask

  // Called right after reset has been released at the start of cycle 0.
  task automatic startup_check();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("start_en", en, 0);
      chk("start_active", active_digit, 7);
      chk("start_frame_done", frame_done, c == 3);
    end
    @(negedge clk);
    chk("start_active0", active_digit, 0);
    chk("start_en1", en, 1);
  endtask

  typedef struct {
    logic [31:0] val;
    logic [7:0]  dp;
    logic        lz;
    logic [7:0]  en_exp;
    logic [7:0]  dp_exp;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic [31:0] old;
    int a0;
    tbl[0] = '{32'h87654321, 8'h04, 1'b0, 8'hFF, 8'h04};
    tbl[1] = '{32'h00000305, 8'h00, 1'b1, 8'h07, 8'h00};
    tbl[2] = '{32'h00000000, 8'h00, 1'b1, 8'h01, 8'h00};
    tbl[3] = '{32'h00000000, 8'h10, 1'b1, 8'h1F, 8'h10};
    tbl[4] = '{32'h00000305, 8'h00, 1'b0, 8'hFF, 8'h00};
    tbl[5] = '{32'h10000000, 8'h01, 1'b1, 8'hFF, 8'h01};
    tbl[6] = '{32'h00000000, 8'h80, 1'b1, 8'hFF, 8'h80};

    reset = 1; display_on = 1; lz_blank = 0; value = 32'h87654321; dp_mask = 8'h04;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    startup_check();

    foreach (tbl[t]) begin
      @(posedge clk); #1;
      value = tbl[t].val; dp_mask = tbl[t].dp; lz_blank = tbl[t].lz;
      wait_frame();
      for (int c = 0; c < 32; c++) begin
        int s;
        @(negedge clk);
        s = c / 4;
        chk("tbl_active", active_digit, s);
        chk("tbl_num", num, (tbl[t].val >> (4 * s)) & 32'hF);
        chk("tbl_en", en, tbl[t].en_exp[s]);
        chk("tbl_dp", dp_ctrl, tbl[t].dp_exp[s]);
      end
    end

    // Mid-frame value change must not tear the current frame.
    @(posedge clk); #1;
    old = 32'h00001234; value = old; dp_mask = 0; lz_blank = 0;
    wait_frame();
    wait_digit(2);
    @(posedge clk); #1 value = 32'h00009999;
    begin
      int n = 0;
      @(negedge clk);
      while (!frame_done && n < 40) begin
        chk("tear_num", num, (old >> (4 * active_digit)) & 32'hF);
        @(negedge clk); n++;
      end
      chk("tear_frame", frame_done, 1);
    end
    @(negedge clk);
    chk("tear_new_active", active_digit, 0);
    chk("tear_new_num", num, 9);

    // display_on has one cycle of latency and does not stop scanning.
    wait_digit(3);
    @(posedge clk); #1 display_on = 0;
    @(negedge clk); chk("disp_lag", en, 1);
    @(negedge clk); chk("disp_off", en, 0);
    a0 = active_digit;
    repeat (8) @(negedge clk);
    chk("disp_scan", active_digit, (a0 + 2) % 8);
    @(posedge clk); #1 display_on = 1;
    @(negedge clk); chk("disp_lag_on", en, 0);
    @(negedge clk); chk("disp_on", en, 1);

    // One-cycle reset mid-frame restarts with startup timing.
    wait_digit(5);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    startup_check();

    // Randomized traffic checked by the model.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) begin
        int top;
        logic [31:0] v;
        top = $urandom_range(0, 8);
        v = 0;
        for (int d = 0; d < 8; d++)
          if (d < top) v = v | (32'($urandom_range(0, 9)) << (4 * d));
        value = v;
      end
      if ($urandom_range(0, 7) == 0)
        dp_mask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) lz_blank = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) display_on = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 reset = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
